// File: rtl/mult_div_seq.sv
// Sequential multiply/divide unit producing a HI/LO result pair.
// Multiply is unsigned shift-add on magnitudes; divide is restoring on magnitudes;
// signs are applied in a single fix-up cycle at the end.
module mult_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] value_A,
    input  logic [WIDTH-1:0] value_B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] low
);

    localparam int unsigned W  = WIDTH;
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + 1;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            div_q, div_d;        // operation is a divide
    logic            negq_q, negq_d;      // negate product / quotient
    logic            negr_q, negr_d;      // negate remainder
    logic            dz_q, dz_d;          // divide by zero in flight
    logic [AW-1:0]   acc_q, acc_d;        // {carry/R msb, P/R, Q}
    logic [W-1:0]    opb_q, opb_d;        // |B|: multiplicand or divisor
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            div_zero_q, div_zero_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    low_q, low_d;

    logic            a_neg_c, b_neg_c;
    logic [W-1:0]    a_mag_c, b_mag_c;
    logic [RW-1:0]   mul_sum_c;
    logic [AW-1:0]   mul_next_c;
    logic [RW-1:0]   div_shift_c, div_diff_c;
    logic            div_ge_c;
    logic [AW-1:0]   div_next_c;
    logic [PW-1:0]   prod_fix_c;
    logic [W-1:0]    quot_fix_c, rem_fix_c;

    // Operand signs and magnitudes; op[0]=1 selects unsigned
    always_comb begin
        a_neg_c = ~op[0] & value_A[W-1];
        b_neg_c = ~op[0] & value_B[W-1];
        a_mag_c = a_neg_c ? -value_A : value_A;
        b_mag_c = b_neg_c ? -value_B : value_B;
    end

    // One shift-add or restoring-divide step, plus the final sign fix-up
    always_comb begin
        mul_sum_c   = {1'b0, acc_q[PW-1:W]} + {1'b0, opb_q};
        mul_next_c  = acc_q[0] ? {1'b0, mul_sum_c, acc_q[W-1:1]}
                               : {1'b0, acc_q[AW-1:1]};
        div_shift_c = {acc_q[PW-1:W], acc_q[W-1]};
        div_ge_c    = div_shift_c >= {1'b0, opb_q};
        div_diff_c  = div_shift_c - {1'b0, opb_q};
        div_next_c  = {(div_ge_c ? div_diff_c : div_shift_c), acc_q[W-2:0], div_ge_c};
        prod_fix_c  = negq_q ? -acc_q[PW-1:0] : acc_q[PW-1:0];
        quot_fix_c  = negq_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem_fix_c   = negr_q ? -acc_q[PW-1:W] : acc_q[PW-1:W];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        dz_d       = dz_q;
        acc_d      = acc_q;
        opb_d      = opb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        low_d      = low_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d     = 1'b1;
                    div_zero_d = 1'b0;
                    div_d      = op[1];
                    negq_d     = a_neg_c ^ b_neg_c;
                    negr_d     = a_neg_c;
                    opb_d      = b_mag_c;
                    cnt_d      = CW'(W);
                    acc_d      = {RW'(0), a_mag_c};
                    dz_d       = 1'b0;
                    if (op[1] && (value_B == '0)) begin
                        // Keep the raw dividend for the divide-by-zero result
                        dz_d    = 1'b1;
                        acc_d   = {RW'(0), value_A};
                        state_d = S_FIX;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_next_c : mul_next_c;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (dz_q) begin
                    hi_d       = acc_q[W-1:0];
                    low_d      = '1;
                    div_zero_d = 1'b1;
                end else if (div_q) begin
                    hi_d  = rem_fix_c;
                    low_d = quot_fix_c;
                end else begin
                    {hi_d, low_d} = prod_fix_c;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            opb_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            low_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            dz_q       <= dz_d;
            acc_q      <= acc_d;
            opb_q      <= opb_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            low_q      <= low_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign low      = low_q;

endmodule
